mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for the multicycle RISC core. It is the responding end of the controller's memory request path: the IorD-selected address plus the MemWrite strobe.
- Accepts one read or write request at a time over a valid/ready handshake.
- Holds the request for a programmable number of wait states, then accesses an internal word RAM.
- Returns the result over a valid/ready response channel.
- Lets the control FSM stall on memory instead of assuming single-cycle access.

Parameters:
DW, 16, data word width in bits
AW, 8, request address width (word address)
DEPTH, 256, RAM words; power of two, DEPTH <= 2**AW
WAIT_CYCLES, 2, wait states between accept and RAM access (0..15)

Ports:
CLK  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; low forces reset state immediately
req_valid  input  1  request present
req_write  input  1  1 = write, 0 = read
req_addr  input  AW  word address
req_wdata  input  DW  write data
req_ready  output  1  responder can accept a request (registered)
rsp_valid  output  1  response present (registered)
rsp_ready  input  1  requester consumes the response
rsp_rdata  output  DW  read data (writes: echo of the written data)
rsp_err  output  1  address out of range (see Optional Feature)

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset low, asynchronous:
  - state = IDLE
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
  - wait counter = 0
  - RAM contents are not reset.
- First rising edge after reset goes high: req_ready <= 1.
- IDLE, req_valid & req_ready at an edge (accept):
  - Capture req_write, req_addr, req_wdata.
  - req_ready <= 0, counter <= WAIT_CYCLES.
  - Go to WAIT; if WAIT_CYCLES == 0, go directly to the access step on the next edge.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter == 0, perform the access:
    - Write: RAM[idx] <= captured wdata; rsp_rdata <= wdata.
    - Read: rsp_rdata <= RAM[idx].
  - Then rsp_valid <= 1, go to RESP.
- Latency: if accept is edge 0, rsp_valid is high after edge WAIT_CYCLES+1.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready at an edge.
  - On that edge: rsp_valid <= 0, rsp_err <= 0, req_ready <= 1, go to IDLE.
- Throughput: at most one request per (WAIT_CYCLES + 3) cycles; no overlapping requests.
- req_valid while busy (req_ready = 0) is ignored. Requester must hold the request until accepted.
- req_valid & req_ready at the same edge that reset is released: not accepted, because req_ready is still 0.
- rsp_ready high outside RESP: no effect.
- Index: idx = captured address mod DEPTH (low log2(DEPTH) bits).
- Reset mid-operation: the in-flight request is discarded.
  - A write is committed only if its access edge occurred before reset fell.
  - No partial response is ever emitted.
- Read-after-write to the same address in back-to-back transactions returns the new data.

Optional Feature:
Macro MEM_RESPONDER_RANGE_CHECK_EN.
- Defined:
  - captured address >= DEPTH means no RAM access.
  - rsp_rdata <= 0, rsp_err <= 1, and a response is still issued with normal latency.
  - In-range addresses give rsp_err = 0.
- Undefined:
  - No range check; address wraps modulo DEPTH.
  - rsp_err is constant 0.

Test Plan:
- Reset:
  - Reset low mid-WAIT of a write to 0x05 (data 0xBEEF).
  - Required: all outputs 0 immediately; RAM[5] unchanged; req_ready = 1 one edge after release.
- Write then read:
  - WAIT_CYCLES=2: write 0x1234 to 0x10, rsp_ready held 1.
  - Required: rsp_valid high 3 edges after accept, rsp_rdata = 0x1234.
  - Read 0x10: rsp_rdata = 0x1234, rsp_err = 0.
- Response backpressure:
  - Read 0x10 with rsp_ready = 0 for 5 cycles.
  - Required: rsp_valid and rsp_rdata = 0x1234 held stable, req_ready = 0 throughout.
  - rsp_ready = 1: rsp_valid = 0 and req_ready = 1 after that edge.
- Busy-request ignore:
  - Hold req_valid with a new address during WAIT.
  - Required: no second accept until back in IDLE; the first response is unaffected.
- Zero wait:
  - WAIT_CYCLES=0: read 0x00 after writing 0x00AA.
  - Required: rsp_valid after 1 edge, rsp_rdata = 0x00AA.
- Range / wrap (DEPTH=128, AW=8), read 0x85 after writing 0x5A5A to 0x05:
  - With MEM_RESPONDER_RANGE_CHECK_EN: rsp_err = 1, rsp_rdata = 0.
  - Without: rsp_rdata = 0x5A5A, rsp_err = 0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: one read/write request at a time into an internal word RAM.
// Latency: response valid WAIT_CYCLES+1 edges after the accepting edge; one transaction in flight.
// Backpressure: req_ready stays low until the response is taken; the response holds until rsp_ready.
// Optional range check: define MEM_RESPONDER_RANGE_CHECK_EN to flag addresses >= DEPTH via rsp_err.
module mem_responder #(
  parameter int DW          = 16,
  parameter int AW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          req_ready,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;

  // RAM is deliberately not reset; only the access step writes it
  logic [DW-1:0]   mem_q [DEPTH];
  logic            mem_we;
  logic [IDXW-1:0] idx;
  logic            oor;

  logic accept;
  logic rsp_fire;

  assign idx      = addr_q[IDXW-1:0];
  assign accept   = (state_q == S_IDLE) && req_valid && req_ready_q;
  assign rsp_fire = (state_q == S_RESP) && rsp_valid_q && rsp_ready;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  assign oor = ({1'b0, addr_q} >= DEPTH_W);
`else
  // Without the range check the address simply wraps; upper bits are don't-care
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q;
  assign oor            = 1'b0;
`endif

  // State and datapath registers; reset discards any in-flight request
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
    end
  end

  // RAM write port, fired only on the access step of an in-range write
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[idx] <= wdata_q;
    end
  end

  // Next-state: accept -> wait out the counter -> hold response until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and datapath: capture on accept, access when the counter expires, release on rsp handshake
  always_comb begin
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Also raises req_ready on the first edge after reset release
        req_ready_d = !accept;
        if (accept) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we      = wr_q && !oor;
          rsp_valid_d = 1'b1;
          err_d       = oor;
          if (oor) begin
            rsp_rdata_d = '0;
          end else if (wr_q) begin
            rsp_rdata_d = wdata_q;
          end else begin
            rsp_rdata_d = mem_q[idx];
          end
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          rsp_valid_d = 1'b0;
          err_d       = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
      end
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign rsp_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q ^ err_d;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=2/DEPTH=128 and WAIT_CYCLES=0/DEPTH=256)
// driven by directed and random transactions, checked every cycle against a transaction-level model.
// Works with and without MEM_RESPONDER_RANGE_CHECK_EN defined.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [2];
  logic        req_write [2];
  logic [7:0]  req_addr [2];
  logic [15:0] req_wdata [2];
  logic        rsp_ready [2];
  logic        req_ready_o [2];
  logic        rsp_valid_o [2];
  logic        rsp_err_o [2];
  logic [15:0] rsp_rdata_o [2];

  int n_vec = 0;
  int n_err = 0;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  always #5 CLK = ~CLK;

  mem_responder #(.DW(16), .AW(8), .DEPTH(128), .WAIT_CYCLES(2)) u0 (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .req_ready(req_ready_o[0]),
    .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata_o[0]), .rsp_err(rsp_err_o[0])
  );

  mem_responder #(.DW(16), .AW(8), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .req_ready(req_ready_o[1]),
    .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata_o[1]), .rsp_err(rsp_err_o[1])
  );

  function automatic int wc(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic int dep(input int k);
    return (k == 0) ? 128 : 256;
  endfunction

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", nm, k, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm, input int k);
    n_vec++;
    n_err++;
    $display("FAIL %s dut%0d: wait bound expired (t=%0t)", nm, k, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [15:0] m_mem [2][256];
  bit          m_known [2][256];
  bit          m_rdy [2], m_vld [2], m_err [2], m_busy [2], m_rknown [2];
  logic [15:0] m_rdata [2];
  bit          m_wr [2];
  logic [7:0]  m_addr [2];
  logic [15:0] m_wdata [2];
  int          m_due [2];
  int          edge_n = 0;

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_rdy[k] = 0; m_vld[k] = 0; m_err[k] = 0; m_busy[k] = 0;
      m_rdata[k] = '0; m_rknown[k] = 1;
    end
  endtask

  // One clock edge: response handshake, else the due access, else a new accept
  task automatic model_step(input int k);
    int idx;
    bit oor;
    if (m_vld[k] && rsp_ready[k]) begin
      m_vld[k] = 0; m_err[k] = 0; m_rdy[k] = 1; m_busy[k] = 0;
    end else if (m_busy[k]) begin
      if (!m_vld[k] && edge_n == m_due[k]) begin
        idx = int'(m_addr[k]) % dep(k);
        oor = RCHK && (int'(m_addr[k]) >= dep(k));
        m_vld[k] = 1;
        m_err[k] = oor;
        m_rknown[k] = 1;
        if (oor) begin
          m_rdata[k] = '0;
        end else if (m_wr[k]) begin
          m_mem[k][idx] = m_wdata[k];
          m_known[k][idx] = 1;
          m_rdata[k] = m_wdata[k];
        end else begin
          m_rdata[k] = m_mem[k][idx];
          m_rknown[k] = m_known[k][idx];
        end
      end
    end else if (m_rdy[k] && req_valid[k]) begin
      m_wr[k] = req_write[k]; m_addr[k] = req_addr[k]; m_wdata[k] = req_wdata[k];
      m_busy[k] = 1; m_rdy[k] = 0;
      m_due[k] = edge_n + wc(k) + 1;
    end else begin
      m_rdy[k] = 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 256; a++) m_known[k][a] = 0;
    model_clear();
    forever begin
      @(posedge CLK);
      if (reset) begin
        edge_n++;
        for (int k = 0; k < 2; k++) model_step(k);
      end
    end
  end

  initial forever begin
    @(negedge reset);
    model_clear();
  end

  // Compare process: every falling edge, both instances against the model
  initial forever begin
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      chk("req_ready", k, 16'(req_ready_o[k]), 16'(m_rdy[k]));
      chk("rsp_valid", k, 16'(rsp_valid_o[k]), 16'(m_vld[k]));
      chk("rsp_err",   k, 16'(rsp_err_o[k]),   16'(m_err[k]));
      if (m_rknown[k]) chk("rsp_rdata", k, rsp_rdata_o[k], m_rdata[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input int k, input bit wr, input logic [7:0] a, input logic [15:0] d,
                     input int hold, input bit poke,
                     output logic [15:0] rd, output logic er, output int lat);
    bit acc;
    bit seen;
    int n;
    rd = '0; er = 1'b0; lat = 0;
    req_valid[k] = 1'b1; req_write[k] = wr; req_addr[k] = a; req_wdata[k] = d;
    rsp_ready[k] = (hold == 0);
    acc = 0; n = 0;
    while (!acc && n < 40) begin
      @(negedge CLK);
      acc = req_ready_o[k];
      @(posedge CLK);
      #1;
      n++;
    end
    if (!acc) begin
      req_valid[k] = 1'b0;
      bound_fail("accept", k);
      return;
    end
    // Optionally keep presenting a different request while busy; it must be ignored
    if (poke) begin
      req_write[k] = 1'b1; req_addr[k] = a ^ 8'h01; req_wdata[k] = ~d;
    end else begin
      req_valid[k] = 1'b0;
    end
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
      @(negedge CLK);
      seen = rsp_valid_o[k];
    end
    req_valid[k] = 1'b0;
    if (!seen) begin
      bound_fail("response", k);
      return;
    end
    rd = rsp_rdata_o[k];
    er = rsp_err_o[k];
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK);
      #1;
      chk("hold_vld", k, 16'(rsp_valid_o[k]), 16'd1);
      chk("hold_rdy", k, 16'(req_ready_o[k]), 16'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge CLK);
    #1;
    rsp_ready[k] = 1'($urandom_range(0, 1));
    chk("post_vld", k, 16'(rsp_valid_o[k]), 16'd0);
    chk("post_rdy", k, 16'(req_ready_o[k]), 16'd1);
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end

    // Reset state, then req_ready rises on the first edge after release
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_rdy",   k, 16'(req_ready_o[k]), 16'd0);
      chk("rst_vld",   k, 16'(rsp_valid_o[k]), 16'd0);
      chk("rst_rdata", k, rsp_rdata_o[k], 16'h0000);
      chk("rst_err",   k, 16'(rsp_err_o[k]), 16'd0);
    end
    @(posedge CLK);
    @(posedge CLK);
    #3 reset = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) chk("rel_rdy", k, 16'(req_ready_o[k]), 16'd1);

    // Write then read, WAIT_CYCLES=2
    txn(0, 1'b1, 8'h10, 16'h1234, 0, 1'b0, rd, er, lat);
    chk("wr_lat", 0, 16'(lat), 16'd3);
    chk("wr_echo", 0, rd, 16'h1234);
    txn(0, 1'b0, 8'h10, 16'h0000, 0, 1'b0, rd, er, lat);
    chk("rd_data", 0, rd, 16'h1234);
    chk("rd_err", 0, 16'(er), 16'd0);

    // Response backpressure for 5 cycles
    txn(0, 1'b0, 8'h10, 16'h0000, 5, 1'b0, rd, er, lat);
    chk("bp_data", 0, rd, 16'h1234);

    // Busy-request ignore: write 0x20 while a write to 0x21 is held during WAIT
    txn(0, 1'b1, 8'h21, 16'h1111, 0, 1'b0, rd, er, lat);
    txn(0, 1'b1, 8'h20, 16'h7777, 0, 1'b1, rd, er, lat);
    chk("busy_echo", 0, rd, 16'h7777);
    txn(0, 1'b0, 8'h21, 16'h0000, 0, 1'b0, rd, er, lat);
    chk("busy_untouched", 0, rd, 16'h1111);

    // Zero wait states
    txn(1, 1'b1, 8'h00, 16'h00AA, 0, 1'b0, rd, er, lat);
    chk("zw_wr_lat", 1, 16'(lat), 16'd1);
    txn(1, 1'b0, 8'h00, 16'h0000, 0, 1'b0, rd, er, lat);
    chk("zw_rd_lat", 1, 16'(lat), 16'd1);
    chk("zw_rd_data", 1, rd, 16'h00AA);

    // Range / wrap with DEPTH=128
    txn(0, 1'b1, 8'h05, 16'h5A5A, 0, 1'b0, rd, er, lat);
    txn(0, 1'b0, 8'h85, 16'h0000, 0, 1'b0, rd, er, lat);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    chk("range_err", 0, 16'(er), 16'd1);
    chk("range_data", 0, rd, 16'h0000);
`else
    chk("wrap_err", 0, 16'(er), 16'd0);
    chk("wrap_data", 0, rd, 16'h5A5A);
`endif

    // Reset falls in mid-WAIT of a write to 0x05; the write must not land
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h05; req_wdata[0] = 16'hBEEF;
    rsp_ready[0] = 1'b1;
    @(posedge CLK);
    #1;
    req_valid[0] = 1'b0;
    @(posedge CLK);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_rdy",   k, 16'(req_ready_o[k]), 16'd0);
      chk("mid_rst_vld",   k, 16'(rsp_valid_o[k]), 16'd0);
      chk("mid_rst_rdata", k, rsp_rdata_o[k], 16'h0000);
      chk("mid_rst_err",   k, 16'(rsp_err_o[k]), 16'd0);
    end
    repeat (2) @(posedge CLK);
    #3 reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("mid_rel_rdy", 0, 16'(req_ready_o[0]), 16'd1);
    txn(0, 1'b0, 8'h05, 16'h0000, 0, 1'b0, rd, er, lat);
    chk("mid_rst_ram", 0, rd, 16'h5A5A);

    // Randomized traffic over a small address set so reads hit written words
    for (int i = 0; i < 300; i++) begin
      int          k;
      bit          wr;
      logic [7:0]  a;
      logic [15:0] d;
      k  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h00;
      a  = a | 8'($urandom_range(0, 7));
      d  = 16'($urandom);
      txn(k, wr, a, d, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rd, er, lat);
    end

    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
